// File: rtl/vga_frame_probe_if.sv
// Registered VGA timing and pixel bundle passed between drawing stages.
// Producers drive it through the out modport, taps read it through in.
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in (
      input vcount, vsync, vblnk,
      input hcount, hsync, hblnk,
      input rgb
   );

   modport out (
      output vcount, vsync, vblnk,
      output hcount, hsync, hblnk,
      output rgb
   );
endinterface

// File: rtl/vga_frame_probe.sv
// Passive per-frame monitor on a vga_if tap: checksum, probe pixel,
// active-pixel count and frame consistency, offered over valid/ready.
module vga_frame_probe #(
   parameter int HOR_PIXELS = 800,
   parameter int VER_PIXELS = 600
) (
   input  logic        clk40MHz,
   input  logic        rst,
   vga_if.in           in_if,
   input  logic [10:0] probe_x,
   input  logic [10:0] probe_y,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_sum,
   output logic [11:0] res_probe_rgb,
   output logic [19:0] res_count,
   output logic        res_frame_err,
   output logic [15:0] res_frame_no,
   output logic        overrun
);

   localparam logic [10:0] X_LAST = 11'(HOR_PIXELS - 1);
   localparam logic [10:0] Y_LAST = 11'(VER_PIXELS - 1);
   localparam logic [10:0] X_NUM  = 11'(HOR_PIXELS);
   localparam logic [10:0] Y_NUM  = 11'(VER_PIXELS);
   localparam logic [19:0] TOTAL  = 20'(HOR_PIXELS * VER_PIXELS);

   typedef enum logic {
      WAIT_SOF,
      ACCUM
   } state_t;

   state_t      state;
   logic [31:0] acc_sum;
   logic [19:0] acc_cnt;
   logic [11:0] acc_prb;
   logic        err_q;
   logic [10:0] px_q;
   logic [10:0] py_q;
   logic        pen_q;
   logic [10:0] exp_x;
   logic [10:0] exp_y;
   logic [15:0] frame_no;

   logic        active;
   logic        sof;
   logic        eof;
   logic        pos_bad;
   logic        probe_in;
   logic        probe_hit;
   logic [10:0] nxt_x;
   logic [10:0] nxt_y;
   logic [31:0] sum_nxt;
   logic [19:0] cnt_nxt;
   logic [11:0] prb_nxt;
   logic        err_nxt;
   logic        unused_sync;

   assign unused_sync = in_if.vsync ^ in_if.hsync;

   // Decode frame markers and form next accumulator values
   always_comb begin
      active    = !in_if.vblnk && !in_if.hblnk;
      sof       = active && in_if.vcount == '0
                  && in_if.hcount == '0;
      eof       = active && in_if.vcount == Y_LAST
                  && in_if.hcount == X_LAST;
      pos_bad   = in_if.hcount != exp_x
                  || in_if.vcount != exp_y;
      probe_in  = probe_x < X_NUM && probe_y < Y_NUM;
      if (sof)
         probe_hit = probe_x == '0 && probe_y == '0;
      else
         probe_hit = pen_q && in_if.hcount == px_q
                     && in_if.vcount == py_q;
      nxt_x = exp_x + 11'd1;
      nxt_y = exp_y;
      if (exp_x == X_LAST) begin
         nxt_x = '0;
         nxt_y = exp_y + 11'd1;
      end
      sum_nxt = acc_sum + {20'd0, in_if.rgb};
      cnt_nxt = (acc_cnt == 20'hFFFFF) ? acc_cnt
                                       : acc_cnt + 20'd1;
      prb_nxt = probe_hit ? in_if.rgb : acc_prb;
      err_nxt = err_q || pos_bad || cnt_nxt != TOTAL;
   end

   // Frame FSM, accumulation, publish and result handshake
   always_ff @(posedge clk40MHz) begin
      if (rst) begin
         state         <= WAIT_SOF;
         acc_sum       <= '0;
         acc_cnt       <= '0;
         acc_prb       <= '0;
         err_q         <= 1'b0;
         px_q          <= '0;
         py_q          <= '0;
         pen_q         <= 1'b0;
         exp_x         <= '0;
         exp_y         <= '0;
         frame_no      <= '0;
         res_valid     <= 1'b0;
         res_sum       <= '0;
         res_probe_rgb <= '0;
         res_count     <= '0;
         res_frame_err <= 1'b0;
         res_frame_no  <= '0;
         overrun       <= 1'b0;
      end else begin
         if (res_valid && res_ready)
            res_valid <= 1'b0;
         if (sof) begin
            state   <= ACCUM;
            acc_sum <= {20'd0, in_if.rgb};
            acc_cnt <= 20'd1;
            acc_prb <= probe_hit ? in_if.rgb : 12'h000;
            err_q   <= state == ACCUM;
            px_q    <= probe_x;
            py_q    <= probe_y;
            pen_q   <= probe_in;
            exp_x   <= 11'd1;
            exp_y   <= '0;
         end else if (state == ACCUM && active) begin
            acc_sum <= sum_nxt;
            acc_cnt <= cnt_nxt;
            acc_prb <= prb_nxt;
            err_q   <= err_q || pos_bad;
            exp_x   <= nxt_x;
            exp_y   <= nxt_y;
            if (eof) begin
               state    <= WAIT_SOF;
               frame_no <= frame_no + 16'd1;
               if (!res_valid) begin
                  res_valid     <= 1'b1;
                  res_sum       <= sum_nxt;
                  res_probe_rgb <= prb_nxt;
                  res_count     <= cnt_nxt;
                  res_frame_err <= err_nxt;
                  res_frame_no  <= frame_no + 16'd1;
               end else begin
                  overrun <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_probe.sv
// Scoreboard bench for vga_frame_probe on a reduced 16x8 raster.
// Frames push expected results; a negedge monitor pops on transfer.
module tb_vga_frame_probe;

   localparam int HOR  = 16;
   localparam int VER  = 8;
   localparam int HTOT = 20;
   localparam int VTOT = 10;

   typedef struct packed {
      logic [31:0] sum;
      logic [11:0] prb;
      logic [19:0] cnt;
      logic        err;
      logic [15:0] no;
   } exp_t;

   logic        clk40MHz = 1'b0;
   logic        rst = 1'b1;
   logic        res_ready = 1'b1;
   logic [10:0] probe_x = '0;
   logic [10:0] probe_y = '0;
   logic        res_valid;
   logic [31:0] res_sum;
   logic [11:0] res_probe_rgb;
   logic [19:0] res_count;
   logic        res_frame_err;
   logic [15:0] res_frame_no;
   logic        overrun;

   vga_if vif ();

   vga_frame_probe #(
      .HOR_PIXELS(HOR),
      .VER_PIXELS(VER)
   ) dut (
      .clk40MHz     (clk40MHz),
      .rst          (rst),
      .in_if        (vif),
      .probe_x      (probe_x),
      .probe_y      (probe_y),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_sum      (res_sum),
      .res_probe_rgb(res_probe_rgb),
      .res_count    (res_count),
      .res_frame_err(res_frame_err),
      .res_frame_no (res_frame_no),
      .overrun      (overrun)
   );

   always #12 clk40MHz = ~clk40MHz;

   exp_t exp_q[$];
   int   rise_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   prev_valid = 1'b0;
   bit   prev_xfer = 1'b0;
   exp_t mon_e;

   always @(posedge clk40MHz) cyc <= cyc + 1;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] s,
                               input logic [11:0] p,
                               input logic [19:0] c,
                               input logic e,
                               input logic [15:0] n);
      exp_t r;
      r.sum = s;
      r.prb = p;
      r.cnt = c;
      r.err = e;
      r.no  = n;
      return r;
   endfunction

   function automatic logic [11:0] pix(input int pat,
                                       input int x,
                                       input int y);
      if (pat == 0)      return 12'h888;
      if (y == 0)        return 12'hff0;
      if (y == VER - 1)  return 12'hf00;
      if (x == 0)        return 12'h0f0;
      if (x == HOR - 1)  return 12'h00f;
      return 12'h111;
   endfunction

   task automatic drive(input int x, input int y,
                        input logic [11:0] c,
                        input bit hb, input bit vb);
      @(posedge clk40MHz);
      #1;
      vif.hcount = 11'(x);
      vif.vcount = 11'(y);
      vif.hblnk  = hb;
      vif.vblnk  = vb;
      vif.rgb    = (hb || vb) ? 12'h000 : c;
      vif.hsync  = x >= HOR + 1 && x < HOR + 3;
      vif.vsync  = y == VER + 1;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 12'h000, 1'b1, 1'b1);
         rst = r;
      end
      rst = 1'b0;
   endtask

   task automatic run_frame(input int pat, input int y0,
                            input int y1, input int drop_y,
                            input int rst_y, input bit pub,
                            input exp_t e);
      if (pub) exp_q.push_back(e);
      for (int y = y0; y < y1; y++) begin
         for (int x = 0; x < HTOT; x++) begin
            bit hb;
            hb = x >= HOR || (y == drop_y && x >= HOR - 5);
            drive(x, y, pix(pat, x, y), hb, y >= VER);
            rst = y == rst_y && x == 0;
            if (pub && x == HOR - 1 && y == VER - 1)
               rise_q.push_back(cyc + 1);
         end
      end
      rst = 1'b0;
   endtask

   // Monitor: result latency, one-cycle valid, fields at transfer
   always @(negedge clk40MHz) begin
      if (mon_en) begin
         if (res_valid && !prev_valid) begin
            if (rise_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_valid: got 1 required 0 cyc %0d",
                        cyc);
            end else begin
               check("valid_latency", cyc, rise_q.pop_front());
            end
         end
         if (prev_xfer)
            check("valid_after_xfer", 32'(res_valid), 0);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_xfer: got no=%0d required none",
                        res_frame_no);
            end else begin
               mon_e = exp_q.pop_front();
               check("sum", res_sum, mon_e.sum);
               check("probe_rgb", 32'(res_probe_rgb), 32'(mon_e.prb));
               check("count", 32'(res_count), 32'(mon_e.cnt));
               check("frame_err", 32'(res_frame_err), 32'(mon_e.err));
               check("frame_no", 32'(res_frame_no), 32'(mon_e.no));
            end
         end
         prev_valid = res_valid;
         prev_xfer  = res_valid && res_ready;
      end
   end

   initial begin
      vif.hcount = '0;
      vif.vcount = '0;
      vif.hblnk  = 1'b1;
      vif.vblnk  = 1'b1;
      vif.hsync  = 1'b0;
      vif.vsync  = 1'b0;
      vif.rgb    = '0;
      idle(3, 1'b1);
      @(negedge clk40MHz);
      check("rst_valid", 32'(res_valid), 0);
      check("rst_sum", res_sum, 0);
      check("rst_probe", 32'(res_probe_rgb), 0);
      check("rst_count", 32'(res_count), 0);
      check("rst_err", 32'(res_frame_err), 0);
      check("rst_no", 32'(res_frame_no), 0);
      check("rst_overrun", 32'(overrun), 0);
      mon_en = 1'b1;

      // uniform field and the three background probes
      probe_x = 11'd10; probe_y = 11'd2;
      run_frame(0, 0, VTOT, -1, -1, 1,
                mk(279552, 12'h888, 128, 0, 1));
      probe_x = 11'd0; probe_y = 11'd0;
      run_frame(1, 0, VTOT, -1, -1, 1,
                mk(151182, 12'hff0, 128, 0, 2));
      probe_x = 11'd15; probe_y = 11'd3;
      run_frame(1, 0, VTOT, -1, -1, 1,
                mk(151182, 12'h00f, 128, 0, 3));
      probe_x = 11'd5; probe_y = 11'd7;
      run_frame(1, 0, VTOT, -1, -1, 1,
                mk(151182, 12'hf00, 128, 0, 4));
      @(negedge clk40MHz);
      check("overrun_clear", 32'(overrun), 0);

      // held result, dropped frame, then release
      res_ready = 1'b0;
      probe_x = 11'd0; probe_y = 11'd0;
      run_frame(0, 0, VTOT, -1, -1, 1,
                mk(279552, 12'h888, 128, 0, 5));
      run_frame(1, 0, VTOT, -1, -1, 0, mk(0, 0, 0, 0, 0));
      @(negedge clk40MHz);
      check("overrun_set", 32'(overrun), 1);
      check("held_valid", 32'(res_valid), 1);
      check("held_no", 32'(res_frame_no), 5);
      @(posedge clk40MHz);
      #1;
      res_ready = 1'b1;
      run_frame(1, 0, VTOT, -1, -1, 1,
                mk(151182, 12'hff0, 128, 0, 7));

      // five pixels dropped on line 3, then a clean frame
      probe_x = 11'd1; probe_y = 11'd2;
      run_frame(0, 0, VTOT, 3, -1, 1,
                mk(268632, 12'h888, 123, 1, 8));
      probe_x = 11'd10; probe_y = 11'd2;
      run_frame(0, 0, VTOT, -1, -1, 1,
                mk(279552, 12'h888, 128, 0, 9));

      // reset pulse at line 4 discards the frame
      run_frame(0, 0, VTOT, -1, 4, 0, mk(0, 0, 0, 0, 0));
      @(negedge clk40MHz);
      check("midrst_overrun", 32'(overrun), 0);
      check("midrst_valid", 32'(res_valid), 0);
      check("midrst_no", 32'(res_frame_no), 0);
      probe_x = 11'd15; probe_y = 11'd3;
      run_frame(1, 0, VTOT, -1, -1, 1,
                mk(151182, 12'h00f, 128, 0, 1));

      // SOF while accumulating restarts and flags the frame
      probe_x = 11'd10; probe_y = 11'd2;
      run_frame(0, 0, 4, -1, -1, 0, mk(0, 0, 0, 0, 0));
      run_frame(0, 0, VTOT, -1, -1, 1,
                mk(279552, 12'h888, 128, 1, 2));

      // stream begins mid-frame after reset
      idle(2, 1'b1);
      probe_x = 11'd5; probe_y = 11'd7;
      run_frame(1, 4, VTOT, -1, -1, 0, mk(0, 0, 0, 0, 0));
      run_frame(1, 0, VTOT, -1, -1, 1,
                mk(151182, 12'hf00, 128, 0, 1));

      // probe outside the active area
      probe_x = 11'd20; probe_y = 11'd2;
      run_frame(0, 0, VTOT, -1, -1, 1,
                mk(279552, 12'h000, 128, 0, 2));

      idle(5, 1'b0);
      @(negedge clk40MHz);
      check("exp_q_drained", 32'(exp_q.size()), 0);
      check("rise_q_drained", 32'(rise_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
